lsu_mem_master: RTL and testbench
=================================

// Module: lsu_mem_master
// PURPOSE
//  CPU-side initiator for the data memory's memread/memwrite/clk_stall protocol. Accepts one
//  load/store at a time from the pipeline (valid/ready), checks alignment and drives a one-cycle
//  request strobe. It then follows clk_stall until the access completes, and returns load data or
//  an error (valid pulse). Sits between the MEM-stage logic and the data memory.
// PARAMETERS
//  TIMEOUT_CYCLES  16  max cycles in WAIT before the access is abandoned with resp_err
// PORTS
//  clk            in   1   clock; all logic on posedge
//  reset          in   1   synchronous, active-high reset
//  req_valid      in   1   pipeline request present
//  req_ready      out  1   block can accept a request this cycle
//  req_write      in   1   1 = store, 0 = load
//  req_addr       in   32  byte address
//  req_wdata      in   32  store data, LSB-aligned (byte in [7:0], half in [15:0])
//  req_size       in   2   0 = byte, 1 = half, 2 = word; 3 = illegal
//  req_signed     in   1   sign-extend load result (ignored for stores)
//  resp_valid     out  1   one-cycle pulse: access finished
//  resp_rdata     out  32  load result (0 for stores and errors)
//  resp_err       out  1   qualified by resp_valid: misaligned, illegal size or timeout
//  mem_addr       out  32  to data memory addr
//  mem_write_data out  32  to data memory write_data
//  mem_memwrite   out  1   to data memory memwrite
//  mem_memread    out  1   to data memory memread
//  mem_sign_mask  out  4   to data memory sign_mask
//  mem_read_data  in   32  from data memory read_data
//  mem_clk_stall  in   1   from data memory clk_stall
// BEHAVIOUR
//  - All outputs registered. Reset: state IDLE, all outputs 0, timeout counter 0, stall_seen 0.
//  - req_ready = (state==IDLE) && !mem_clk_stall && !reset. Accept = req_valid && req_ready.
//  - sign_mask = {req_signed & ~req_write, mask}: mask byte 3'b001, half 3'b011, word 3'b111.
//  - Misaligned cases (no memory access is made): half with addr[0]=1, word with addr[1:0]!=0,
//    or size==3. Any of these on accept -> RESP with resp_err=1.
//  - States:
//    IDLE : on a legal accept, latch mem_addr, mem_sign_mask and the strobe
//           (memread=~write, memwrite=write); mem_write_data = write ? wdata : 0.
//           Then go to ISSUE. An illegal accept goes to RESP.
//    ISSUE: lasts exactly one cycle (the memory samples the strobe here).
//           Clear memread/memwrite, clear the counter and stall_seen, then go to WAIT.
//    WAIT : count each cycle. Set stall_seen when mem_clk_stall==1.
//           If stall_seen && !mem_clk_stall: resp_valid=1, resp_err=0,
//           resp_rdata = load ? mem_read_data : 0, then go to IDLE.
//           If the counter reaches TIMEOUT_CYCLES first: resp_valid=1, resp_err=1,
//           resp_rdata=0, then go to IDLE.
//    RESP : resp_valid=1, resp_err=1, resp_rdata=0, then go to IDLE.
//  - resp_valid is high for exactly one cycle and is 0 in every other cycle.
//  - Latency, legal access: accept at edge A -> resp_valid high after edge A+4.
//    A+1: memory raises stall. A+3: memory drops stall and read data is valid.
//    A+4: block samples stall low and captures the data.
//  - Latency, error: resp_valid high after edge A+1.
//  - No pipelining: the next accept is possible on the edge after resp_valid.
//    This is legal because the memory is already back in IDLE.
//  - mem_addr and mem_sign_mask hold their values after ISSUE until the next accept.
//  - Reset mid-access: the block returns to IDLE and the outputs clear. The memory has no reset
//    and finishes its access; req_ready stays low while mem_clk_stall=1, so no request is lost.
// TESTING
//  - Word load, mem word 0x8000_00F0 at 0x40 -> memread pulse 1 cycle;
//    resp_valid 4 cycles after accept; resp_rdata=0x8000_00F0, resp_err=0.
//  - Signed byte load addr 0x43, size 0, same word -> mem_sign_mask=4'b1001;
//    resp_rdata=0xFFFF_FF80.
//  - Half store addr 0x42, wdata 0x1234_ABCD -> memwrite pulse 1 cycle, sign_mask=4'b0011;
//    a later word load returns 0xABCD_00F0.
//  - Misaligned word load addr 0x41 -> no memread/memwrite; resp_valid+resp_err one cycle after
//    accept. Size 3 behaves the same.
//  - Stub memory holds mem_clk_stall=0 forever -> resp_err after TIMEOUT_CYCLES in WAIT;
//    req_ready returns next cycle.
//  - Reset asserted in WAIT -> outputs 0 next cycle; req_ready held low until the memory drops
//    stall; the next load completes correctly.

Source files
------------

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: single-outstanding load/store initiator for the data memory.
// Ports: req_* pipeline handshake in, resp_* result pulse out, mem_* memory side.
module lsu_mem_master #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_memwrite,
    output logic        mem_memread,
    output logic [3:0]  mem_sign_mask,
    input  logic [31:0] mem_read_data,
    input  logic        mem_clk_stall
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t state_q, state_d;

    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          memwrite_q, memwrite_d;
    logic          memread_q, memread_d;
    logic [3:0]    mask_q, mask_d;
    logic          rvalid_q, rvalid_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          rerr_q, rerr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          stall_seen_q, stall_seen_d;
    logic          load_q, load_d;

    logic          accept;
    logic          misalign;
    logic [2:0]    size_mask;
    logic [CW-1:0] cnt_inc;

    assign req_ready = (state_q == S_IDLE) && !mem_clk_stall && !reset;
    assign accept    = req_valid && req_ready;
    assign cnt_inc   = cnt_q + CW'(1);

    always_comb begin
        misalign = (req_size == 2'd3)
                || ((req_size == 2'd1) && req_addr[0])
                || ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
        size_mask = 3'b000;
        unique case (req_size)
            2'd0:    size_mask = 3'b001;
            2'd1:    size_mask = 3'b011;
            2'd2:    size_mask = 3'b111;
            default: size_mask = 3'b000;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        memwrite_d   = memwrite_q;
        memread_d    = memread_q;
        mask_d       = mask_q;
        rvalid_d     = 1'b0;
        rdata_d      = 32'h0;
        rerr_d       = 1'b0;
        cnt_d        = cnt_q;
        stall_seen_d = stall_seen_q;
        load_d       = load_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (misalign) begin
                        state_d = S_RESP;
                    end else begin
                        addr_d     = req_addr;
                        mask_d     = {req_signed & ~req_write, size_mask};
                        memread_d  = ~req_write;
                        memwrite_d = req_write;
                        load_d     = ~req_write;
                        wdata_d    = req_write ? req_wdata : 32'h0;
                        state_d    = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                memread_d    = 1'b0;
                memwrite_d   = 1'b0;
                cnt_d        = '0;
                stall_seen_d = 1'b0;
                state_d      = S_WAIT;
            end
            S_WAIT: begin
                cnt_d        = cnt_inc;
                stall_seen_d = stall_seen_q | mem_clk_stall;
                // Completion is the falling edge of stall after we saw it rise.
                if (stall_seen_q && !mem_clk_stall) begin
                    rvalid_d = 1'b1;
                    rdata_d  = load_q ? mem_read_data : 32'h0;
                    state_d  = S_IDLE;
                end else if (cnt_inc == CW'(TIMEOUT_CYCLES)) begin
                    rvalid_d = 1'b1;
                    rerr_d   = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            S_RESP: begin
                rvalid_d = 1'b1;
                rerr_d   = 1'b1;
                state_d  = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            memwrite_q   <= 1'b0;
            memread_q    <= 1'b0;
            mask_q       <= 4'h0;
            rvalid_q     <= 1'b0;
            rdata_q      <= 32'h0;
            rerr_q       <= 1'b0;
            cnt_q        <= '0;
            stall_seen_q <= 1'b0;
            load_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            memwrite_q   <= memwrite_d;
            memread_q    <= memread_d;
            mask_q       <= mask_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            rerr_q       <= rerr_d;
            cnt_q        <= cnt_d;
            stall_seen_q <= stall_seen_d;
            load_q       <= load_d;
        end
    end

    assign mem_addr       = addr_q;
    assign mem_write_data = wdata_q;
    assign mem_memwrite   = memwrite_q;
    assign mem_memread    = memread_q;
    assign mem_sign_mask  = mask_q;
    assign resp_valid     = rvalid_q;
    assign resp_rdata     = rdata_q;
    assign resp_err       = rerr_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// tb_lsu_mem_master: directed bench with a stall-protocol data memory stub.
// Each task drives one scenario and compares against hand-computed values.
module tb_lsu_mem_master;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [1:0]  req_size = 2'd0;
    logic        req_signed = 1'b0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_memwrite;
    logic        mem_memread;
    logic [3:0]  mem_sign_mask;
    logic [31:0] mem_read_data = 32'h0;
    logic        mem_clk_stall = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    lsu_mem_master #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_size(req_size),
        .req_signed(req_signed),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_memwrite(mem_memwrite), .mem_memread(mem_memread),
        .mem_sign_mask(mem_sign_mask),
        .mem_read_data(mem_read_data), .mem_clk_stall(mem_clk_stall)
    );

    always #5 clk = ~clk;

    // Memory stub: samples the strobe, stalls for two edges, then completes.
    logic [31:0] mem [0:63] = '{16: 32'h8000_00F0, default: 32'h0};
    logic        dead = 1'b0;
    logic        mbusy = 1'b0;
    logic        mcnt = 1'b0;
    logic        m_rd = 1'b0;
    logic [31:0] m_addr = 32'h0;
    logic [31:0] m_wd = 32'h0;
    logic [3:0]  m_mask = 4'h0;

    function automatic logic [31:0] rd_shape(input logic [31:0] w,
                                             input logic [1:0] off,
                                             input logic [3:0] m);
        logic [31:0] s;
        s = w >> (8 * off);
        case (m[2:0])
            3'b001:  return {{24{m[3] & s[7]}}, s[7:0]};
            3'b011:  return {{16{m[3] & s[15]}}, s[15:0]};
            default: return s;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!mbusy) begin
            if (!dead && (mem_memread || mem_memwrite)) begin
                mbusy <= 1'b1;
                mcnt <= 1'b0;
                mem_clk_stall <= 1'b1;
                m_rd <= mem_memread;
                m_addr <= mem_addr;
                m_wd <= mem_write_data;
                m_mask <= mem_sign_mask;
            end
        end else if (!mcnt) begin
            mcnt <= 1'b1;
        end else begin
            mbusy <= 1'b0;
            mem_clk_stall <= 1'b0;
            if (m_rd) begin
                mem_read_data <= rd_shape(mem[m_addr[7:2]], m_addr[1:0], m_mask);
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (b >= int'(m_addr[1:0]) && m_mask[b - int'(m_addr[1:0])])
                        mem[m_addr[7:2]][8*b +: 8] <= m_wd[8*(b - int'(m_addr[1:0])) +: 8];
                end
            end
        end
    end

    // Issue one request and follow it to its response (bounded).
    int          o_lat, o_nrd, o_nwr;
    logic [31:0] o_rdata, o_addr;
    logic        o_err, o_ready;
    logic [3:0]  o_mask;
    logic [31:0] o_wd;

    task automatic issue(input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [1:0] sz,
                         input logic sg);
        int n;
        n = 0;
        while (!req_ready && n < 40) begin
            @(posedge clk); #1; n++;
        end
        req_write = w; req_addr = a; req_wdata = d;
        req_size = sz; req_signed = sg; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        o_mask = mem_sign_mask;
        o_wd = mem_write_data;
        o_nrd = int'(mem_memread);
        o_nwr = int'(mem_memwrite);
        o_lat = 0;
        while (!resp_valid && o_lat < 40) begin
            @(posedge clk); #1;
            o_lat++;
            o_nrd += int'(mem_memread);
            o_nwr += int'(mem_memwrite);
        end
        o_rdata = resp_rdata;
        o_err = resp_err;
        o_ready = req_ready;
        o_addr = mem_addr;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %b want 0", resp_valid); end
        vectors++; if (resp_err !== 1'b0) begin miscompares++; $display("FAIL rst_err got %b want 0", resp_err); end
        vectors++; if (resp_rdata !== 32'h0) begin miscompares++; $display("FAIL rst_rdata got %h want 0", resp_rdata); end
        vectors++; if (mem_addr !== 32'h0) begin miscompares++; $display("FAIL rst_addr got %h want 0", mem_addr); end
        vectors++; if (mem_write_data !== 32'h0) begin miscompares++; $display("FAIL rst_wdata got %h want 0", mem_write_data); end
        vectors++; if ({mem_memread, mem_memwrite} !== 2'b00) begin miscompares++; $display("FAIL rst_strobe got %b want 00", {mem_memread, mem_memwrite}); end
        vectors++; if (mem_sign_mask !== 4'h0) begin miscompares++; $display("FAIL rst_mask got %b want 0000", mem_sign_mask); end
        vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready_in_reset got %b want 0", req_ready); end
        reset = 1'b0;
        #1;
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready_after got %b want 1", req_ready); end
    endtask

    task automatic test_word_load;
        issue(1'b0, 32'h40, 32'h0, 2'd2, 1'b0);
        vectors++; if (o_mask !== 4'b0111) begin miscompares++; $display("FAIL wl_mask got %b want 0111", o_mask); end
        vectors++; if (o_nrd !== 1) begin miscompares++; $display("FAIL wl_memread_cycles got %0d want 1", o_nrd); end
        vectors++; if (o_nwr !== 0) begin miscompares++; $display("FAIL wl_memwrite_cycles got %0d want 0", o_nwr); end
        vectors++; if (o_lat !== 4) begin miscompares++; $display("FAIL wl_latency got %0d want 4", o_lat); end
        vectors++; if (o_rdata !== 32'h8000_00F0) begin miscompares++; $display("FAIL wl_rdata got %h want 800000f0", o_rdata); end
        vectors++; if (o_err !== 1'b0) begin miscompares++; $display("FAIL wl_err got %b want 0", o_err); end
        @(posedge clk); #1;
        vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL wl_valid_pulse got %b want 0", resp_valid); end
    endtask

    task automatic test_signed_byte;
        issue(1'b0, 32'h43, 32'h0, 2'd0, 1'b1);
        vectors++; if (o_mask !== 4'b1001) begin miscompares++; $display("FAIL sb_mask got %b want 1001", o_mask); end
        vectors++; if (o_rdata !== 32'hFFFF_FF80) begin miscompares++; $display("FAIL sb_rdata got %h want ffffff80", o_rdata); end
        vectors++; if (o_lat !== 4) begin miscompares++; $display("FAIL sb_latency got %0d want 4", o_lat); end
    endtask

    task automatic test_half_store_back_to_back;
        issue(1'b1, 32'h42, 32'h1234_ABCD, 2'd1, 1'b1);
        vectors++; if (o_mask !== 4'b0011) begin miscompares++; $display("FAIL hs_mask got %b want 0011", o_mask); end
        vectors++; if (o_wd !== 32'h1234_ABCD) begin miscompares++; $display("FAIL hs_wdata got %h want 1234abcd", o_wd); end
        vectors++; if (o_nwr !== 1) begin miscompares++; $display("FAIL hs_memwrite_cycles got %0d want 1", o_nwr); end
        vectors++; if (o_nrd !== 0) begin miscompares++; $display("FAIL hs_memread_cycles got %0d want 0", o_nrd); end
        vectors++; if ({o_err, o_rdata} !== 33'h0) begin miscompares++; $display("FAIL hs_resp got err=%b rdata=%h want 0/0", o_err, o_rdata); end
        vectors++; if (o_addr !== 32'h42) begin miscompares++; $display("FAIL hs_addr_hold got %h want 42", o_addr); end
        vectors++; if (o_ready !== 1'b1) begin miscompares++; $display("FAIL hs_ready_at_resp got %b want 1", o_ready); end
        issue(1'b0, 32'h40, 32'h0, 2'd2, 1'b0);
        vectors++; if (o_rdata !== 32'hABCD_00F0) begin miscompares++; $display("FAIL b2b_rdata got %h want abcd00f0", o_rdata); end
        vectors++; if (o_lat !== 4) begin miscompares++; $display("FAIL b2b_latency got %0d want 4", o_lat); end
        issue(1'b0, 32'h43, 32'h0, 2'd0, 1'b0);
        vectors++; if (o_rdata !== 32'h0000_00AB) begin miscompares++; $display("FAIL ub_rdata got %h want 000000ab", o_rdata); end
    endtask

    task automatic test_misaligned;
        logic [31:0] addrs [3] = '{32'h41, 32'h40, 32'h43};
        logic [1:0]  sizes [3] = '{2'd2, 2'd3, 2'd1};
        for (int i = 0; i < 3; i++) begin
            issue(1'b0, addrs[i], 32'h0, sizes[i], 1'b0);
            vectors++; if (o_lat !== 1) begin miscompares++; $display("FAIL mis%0d_latency got %0d want 1", i, o_lat); end
            vectors++; if (o_nrd + o_nwr !== 0) begin miscompares++; $display("FAIL mis%0d_strobes got %0d want 0", i, o_nrd + o_nwr); end
            vectors++; if (o_err !== 1'b1) begin miscompares++; $display("FAIL mis%0d_err got %b want 1", i, o_err); end
            vectors++; if (o_rdata !== 32'h0) begin miscompares++; $display("FAIL mis%0d_rdata got %h want 0", i, o_rdata); end
            @(posedge clk); #1;
            vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL mis%0d_pulse got %b want 0", i, resp_valid); end
        end
    endtask

    task automatic test_timeout;
        dead = 1'b1;
        issue(1'b0, 32'h40, 32'h0, 2'd2, 1'b0);
        vectors++; if (o_lat !== 17) begin miscompares++; $display("FAIL to_latency got %0d want 17", o_lat); end
        vectors++; if (o_err !== 1'b1) begin miscompares++; $display("FAIL to_err got %b want 1", o_err); end
        vectors++; if (o_rdata !== 32'h0) begin miscompares++; $display("FAIL to_rdata got %h want 0", o_rdata); end
        vectors++; if (o_ready !== 1'b1) begin miscompares++; $display("FAIL to_ready got %b want 1", o_ready); end
        dead = 1'b0;
        @(posedge clk); #1;
        vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL to_pulse got %b want 0", resp_valid); end
    endtask

    task automatic test_reset_mid_access;
        req_write = 1'b0; req_addr = 32'h40; req_size = 2'd2;
        req_signed = 1'b0; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL rm_ready_reset got %b want 0", req_ready); end
        @(posedge clk); #1;
        vectors++; if ({resp_valid, mem_memread, mem_memwrite} !== 3'b000) begin miscompares++; $display("FAIL rm_outputs got %b want 000", {resp_valid, mem_memread, mem_memwrite}); end
        vectors++; if ({mem_addr, mem_sign_mask} !== 36'h0) begin miscompares++; $display("FAIL rm_addr_mask got %h/%b want 0/0", mem_addr, mem_sign_mask); end
        reset = 1'b0;
        #1;
        vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL rm_ready_stall got %b want 0", req_ready); end
        @(posedge clk); #1;
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL rm_ready_release got %b want 1", req_ready); end
        vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL rm_no_resp got %b want 0", resp_valid); end
        issue(1'b0, 32'h40, 32'h0, 2'd2, 1'b0);
        vectors++; if (o_rdata !== 32'hABCD_00F0) begin miscompares++; $display("FAIL rm_next_rdata got %h want abcd00f0", o_rdata); end
        vectors++; if ({o_err, o_lat} !== {1'b0, 32'd4}) begin miscompares++; $display("FAIL rm_next_resp got err=%b lat=%0d want 0/4", o_err, o_lat); end
    endtask

    initial begin
        test_reset();
        test_word_load();
        test_signed_byte();
        test_half_store_back_to_back();
        test_misaligned();
        test_timeout();
        test_reset_mid_access();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
